// File: rtl/cordic_phase_engine.sv
// Pipelined CORDIC vectoring engine: {imag,real} -> atan2 phase, with bin index and frame marker kept aligned.
// Define CORDIC_PHASE_MAG_EN to add the m_mag output (final x, uncompensated CORDIC gain ~1.6468).
module cordic_phase_engine #(
    parameter int DATA_WIDTH    = 24,
    parameter int PHASE_WIDTH   = 24,
    parameter int ADDR_WIDTH    = 11,
    parameter int STAGES        = 22,
    parameter int HALF_SPECTRUM = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2*DATA_WIDTH-1:0] s_tdata,
    input  logic [ADDR_WIDTH-1:0]   s_tuser,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [PHASE_WIDTH-1:0]  m_phase,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic                    m_last,
    output logic                    m_valid,
`ifdef CORDIC_PHASE_MAG_EN
    output logic [DATA_WIDTH+1:0]   m_mag,
`endif
    input  logic                    m_ready
);
    localparam int XW   = DATA_WIDTH + 2;
    localparam int FRAC = PHASE_WIDTH - 3;
    localparam longint PI60 = 64'sd3622009729038561421;  // pi * 2^60
    localparam logic [ADDR_WIDTH-1:0] LAST_LOW = {1'b0, {(ADDR_WIDTH-1){1'b1}}};

    typedef logic [STAGES-1:0][PHASE_WIDTH-1:0] tab_t;

    function automatic logic [PHASE_WIDTH-1:0] round_frac(input longint v);
        longint r;
        r = (v + (64'sd1 <<< (59 - FRAC))) >>> (60 - FRAC);
        return r[PHASE_WIDTH-1:0];
    endfunction

    // atan(2^-i) by its Taylor series in 60-bit fixed point; i=0 is pi/4 directly.
    function automatic tab_t build_atan();
        tab_t   t;
        longint acc;
        longint term;
        for (int i = 0; i < STAGES; i++) begin
            acc = 0;
            if (i == 0) begin
                acc = PI60 >>> 2;
            end else begin
                for (int k = 0; k < 32; k++) begin
                    if (i * (2 * k + 1) <= 60) begin
                        term = (64'sd1 <<< (60 - i * (2 * k + 1))) / longint'(2 * k + 1);
                        acc  = (k % 2 == 0) ? acc + term : acc - term;
                    end
                end
            end
            t[i] = round_frac(acc);
        end
        return t;
    endfunction

    localparam tab_t ATAN = build_atan();
    localparam logic signed [PHASE_WIDTH-1:0] PI_Z = round_frac(PI60);

    logic                          en;
    logic                          drop_bin;
    logic                          last_in;
    logic signed [XW-1:0]          re, im;
    logic [STAGES:0]               vld_pipe, last_pipe;
    logic [ADDR_WIDTH-1:0]         addr_pipe [0:STAGES];
    logic signed [XW-1:0]          x_pipe [0:STAGES], x_next [0:STAGES];
    logic signed [XW-1:0]          y_pipe [0:STAGES], y_next [0:STAGES];
    logic signed [PHASE_WIDTH-1:0] z_pipe [0:STAGES], z_next [0:STAGES];

    assign en       = ~m_valid | m_ready;
    assign s_tready = en;
    assign re       = {{2{s_tdata[DATA_WIDTH-1]}}, s_tdata[DATA_WIDTH-1:0]};
    assign im       = {{2{s_tdata[2*DATA_WIDTH-1]}}, s_tdata[2*DATA_WIDTH-1:DATA_WIDTH]};
    // Upper-half bins are still consumed but travel as bubbles.
    assign drop_bin = (HALF_SPECTRUM != 0) && s_tuser[ADDR_WIDTH-1];
    assign last_in  = (HALF_SPECTRUM != 0) ? (s_tuser == LAST_LOW) : s_tlast;

    always_comb begin
        x_next[0] = re;
        y_next[0] = im;
        z_next[0] = '0;
        // Fold the left half-plane onto the right and seed z with +-pi.
        if (re[XW-1]) begin
            x_next[0] = -re;
            y_next[0] = -im;
            z_next[0] = im[XW-1] ? -PI_Z : PI_Z;
        end
        for (int i = 0; i < STAGES; i++) begin
            x_next[i+1] = x_pipe[i];
            y_next[i+1] = y_pipe[i];
            z_next[i+1] = z_pipe[i];
            // y == 0 means the vector already lies on the axis: no rotation.
            if (y_pipe[i] != 0) begin
                if (!y_pipe[i][XW-1]) begin
                    x_next[i+1] = x_pipe[i] + (y_pipe[i] >>> i);
                    y_next[i+1] = y_pipe[i] - (x_pipe[i] >>> i);
                    z_next[i+1] = z_pipe[i] + ATAN[i];
                end else begin
                    x_next[i+1] = x_pipe[i] - (y_pipe[i] >>> i);
                    y_next[i+1] = y_pipe[i] + (x_pipe[i] >>> i);
                    z_next[i+1] = z_pipe[i] - ATAN[i];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_phase  <= '0;
            m_addr   <= '0;
`ifdef CORDIC_PHASE_MAG_EN
            m_mag    <= '0;
`endif
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], s_tvalid & ~drop_bin};
            m_valid  <= vld_pipe[STAGES];
            m_last   <= vld_pipe[STAGES] & last_pipe[STAGES];
            m_phase  <= z_pipe[STAGES];
            m_addr   <= addr_pipe[STAGES];
`ifdef CORDIC_PHASE_MAG_EN
            m_mag    <= x_pipe[STAGES];
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (en) begin
            x_pipe       <= x_next;
            y_pipe       <= y_next;
            z_pipe       <= z_next;
            last_pipe    <= {last_pipe[STAGES-1:0], last_in};
            addr_pipe[0] <= s_tuser;
            for (int i = 0; i < STAGES; i++) addr_pipe[i+1] <= addr_pipe[i];
        end
    end
endmodule

// File: tb/tb_cordic_phase_engine.sv
// Scoreboard bench: one half-spectrum instance (u=0) and one full-spectrum instance (u=1),
// expected phases from real-valued atan2.
module tb_cordic_phase_engine;
    localparam int DW = 24, PW = 24, AW = 11, ST = 22, LAT = ST + 2;
    localparam int PI_LSB = 6588397;
    localparam int HALF_PT = 4194304;

    typedef struct {
        int     phase;
        int     addr;
        bit     last;
        int     acc_cyc;
        bit     chk_lat;
        bit     chk_mag;
        longint mag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2*DW-1:0] s_tdata [2];
    logic [AW-1:0]   s_tuser [2];
    logic            s_tlast [2], s_tvalid [2], s_tready [2];
    logic [PW-1:0]   m_phase [2];
    logic [AW-1:0]   m_addr  [2];
    logic            m_last  [2], m_valid [2], m_ready [2];
`ifdef CORDIC_PHASE_MAG_EN
    logic [DW+1:0]   m_mag   [2];
`endif

    cordic_phase_engine #(.HALF_SPECTRUM(1)) dut_half (
        .clock(clk), .reset(rst), .s_tdata(s_tdata[0]), .s_tuser(s_tuser[0]), .s_tlast(s_tlast[0]),
        .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]), .m_phase(m_phase[0]), .m_addr(m_addr[0]),
        .m_last(m_last[0]), .m_valid(m_valid[0]),
`ifdef CORDIC_PHASE_MAG_EN
        .m_mag(m_mag[0]),
`endif
        .m_ready(m_ready[0]));

    cordic_phase_engine #(.HALF_SPECTRUM(0)) dut_full (
        .clock(clk), .reset(rst), .s_tdata(s_tdata[1]), .s_tuser(s_tuser[1]), .s_tlast(s_tlast[1]),
        .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]), .m_phase(m_phase[1]), .m_addr(m_addr[1]),
        .m_last(m_last[1]), .m_valid(m_valid[1]),
`ifdef CORDIC_PHASE_MAG_EN
        .m_mag(m_mag[1]),
`endif
        .m_ready(m_ready[1]));

    exp_t q0[$], q1[$];
    int   n_pass = 0, n_total = 0, cyc = 0, extra = 0;
    bit   rnd_rdy = 1'b0;
    real  kgain = 1.0;
    logic          hv [2];
    logic [PW-1:0] hp [2];
    logic [AW-1:0] ha [2];
    logic          hl [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string nm, input bit ok, input longint act, input longint expv);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    endtask

    // Reference: exact atan2 rounded to 21 fractional bits; half-spectrum drops idx >= 1024.
    task automatic push(input int u, input int re, input int im, input int idx, input bit lst,
                        input bit lat, input bit mg);
        exp_t e;
        real  a;
        if (u == 0 && idx >= 1024) return;
        a = (re == 0 && im == 0) ? 0.0 : $atan2(real'(im), real'(re));
        e.phase   = $rtoi(a * 2097152.0 + ((a < 0.0) ? -0.5 : 0.5));
        e.addr    = idx;
        e.last    = (u == 0) ? (idx == 1023) : lst;
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        e.chk_mag = mg;
        e.mag     = longint'($rtoi(kgain * $sqrt(real'(re) * real'(re) + real'(im) * real'(im)) + 0.5));
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int u);
        exp_t e;
        int   d;
        if (hv[u])
            chk("stall_hold", m_valid[u] && m_phase[u] == hp[u] && m_addr[u] == ha[u] && m_last[u] == hl[u],
                longint'(m_addr[u]), longint'(ha[u]));
        hv[u] = m_valid[u] && !m_ready[u];
        hp[u] = m_phase[u];
        ha[u] = m_addr[u];
        hl[u] = m_last[u];
        if (m_valid[u] && m_ready[u]) begin
            if (qsize(u) == 0) begin
                extra++;
                chk("unexpected_out", 1'b0, longint'(m_addr[u]), -1);
            end else begin
                if (u == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                d = int'(signed'(m_phase[u])) - e.phase;
                if (d > PI_LSB) d -= 2 * PI_LSB;
                else if (d < -PI_LSB) d += 2 * PI_LSB;
                chk("phase", iabs(d) <= 8, longint'(signed'(m_phase[u])), e.phase);
                chk("addr", m_addr[u] == AW'(e.addr), longint'(m_addr[u]), e.addr);
                chk("last", m_last[u] == e.last, longint'(m_last[u]), longint'(e.last));
                if (e.chk_lat) chk("latency", cyc - e.acc_cyc == LAT, cyc - e.acc_cyc, LAT);
`ifdef CORDIC_PHASE_MAG_EN
                if (e.chk_mag) chk("mag", iabs(int'(m_mag[u]) - int'(e.mag)) <= 8, longint'(m_mag[u]), e.mag);
`endif
            end
        end
    endtask

    initial begin
        hv[0] = 1'b0;
        hv[1] = 1'b0;
        forever begin
            @(negedge clk);
            mon(0);
            mon(1);
        end
    end

    initial begin
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) m_ready[u] = rnd_rdy ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge, leaving s_tvalid high.
    task automatic send(input int u, input int re, input int im, input int idx, input bit lst,
                        input bit lat, input bit mg);
        int t;
        s_tdata[u]  = {im[DW-1:0], re[DW-1:0]};
        s_tuser[u]  = idx[AW-1:0];
        s_tlast[u]  = lst;
        s_tvalid[u] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_tready[u] && t < 1000);
        if (!s_tready[u]) chk("send_timeout", 1'b0, t, 1000);
        else push(u, re, im, idx, lst, lat, mg);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int u, input int n);
        s_tvalid[u] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int u);
        s_tvalid[u] = 1'b0;
        for (int t = 0; t < 20000 && qsize(u) > 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", qsize(u) == 0, qsize(u), 0);
        rnd_rdy = 1'b0;
        idle_cycles(u, 3);
    endtask

    task automatic rnd_bin(output int re, output int im);
        do begin
            re = int'($urandom_range(0, 16777215)) - 8388608;
            im = int'($urandom_range(0, 16777215)) - 8388608;
        end while (iabs(re) < HALF_PT && iabs(im) < HALF_PT);
    endtask

    task automatic check_reset_state(input int u);
        chk("rst_valid", m_valid[u] == 1'b0, longint'(m_valid[u]), 0);
        chk("rst_phase", m_phase[u] == '0, longint'(m_phase[u]), 0);
        chk("rst_addr", m_addr[u] == '0, longint'(m_addr[u]), 0);
        chk("rst_last", m_last[u] == 1'b0, longint'(m_last[u]), 0);
    endtask

    initial begin
        int re, im;
        for (int i = 0; i < ST; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));
        for (int u = 0; u < 2; u++) begin
            s_tdata[u] = '0; s_tuser[u] = '0; s_tlast[u] = 1'b0; s_tvalid[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) check_reset_state(u);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", s_tready[0] == 1'b1, longint'(s_tready[0]), 1);
        @(posedge clk);
        #1;

        // single bin latency and zero phase
        send(0, HALF_PT, 0, 5, 1'b0, 1'b1, 1'b0);
        drain(0);

        // quadrants, axes, -FS, zero input
        send(0, HALF_PT, HALF_PT, 10, 1'b0, 1'b0, 1'b0);
        send(0, -HALF_PT, HALF_PT, 11, 1'b0, 1'b0, 1'b0);
        send(0, -HALF_PT, -HALF_PT, 12, 1'b0, 1'b0, 1'b0);
        send(0, HALF_PT, -HALF_PT, 13, 1'b0, 1'b0, 1'b0);
        send(0, -HALF_PT, 0, 14, 1'b0, 1'b0, 1'b0);
        send(0, -8388608, 0, 15, 1'b0, 1'b0, 1'b0);
        send(0, 0, HALF_PT, 16, 1'b0, 1'b0, 1'b0);
        send(0, 0, 0, 17, 1'b0, 1'b0, 1'b0);
`ifdef CORDIC_PHASE_MAG_EN
        send(0, 5033165, 6710886, 18, 1'b0, 1'b0, 1'b1);
`endif
        drain(0);

        // half-spectrum random stream with random backpressure and gaps
        rnd_rdy = 1'b1;
        for (int idx = 0; idx < 2048; idx++) begin
            rnd_bin(re, im);
            send(0, re, im, idx, ($urandom % 8 == 0) || idx == 2047, 1'b0, 1'b0);
            if ($urandom % 10 == 0) idle_cycles(0, 1);
        end
        drain(0);

        // full-spectrum stream with zero bins
        rnd_rdy = 1'b1;
        for (int idx = 0; idx < 2048; idx++) begin
            if (idx % 128 == 7) begin re = 0; im = 0; end
            else rnd_bin(re, im);
            send(1, re, im, idx, idx == 2047, 1'b0, 1'b0);
        end
        drain(1);

        // reset with samples in flight and output valid
        for (int idx = 100; idx < 130; idx++) begin
            rnd_bin(re, im);
            send(0, re, im, idx, 1'b0, 1'b0, 1'b0);
        end
        s_tvalid[0] = 1'b0;
        @(negedge clk);
        #2;
        chk("valid_before_reset", m_valid[0] == 1'b1, longint'(m_valid[0]), 1);
        rst = 1'b1;
        #1;
        check_reset_state(0);
        q0.delete();
        extra = 0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("no_stale", extra == 0, extra, 0);
        chk("idle_after_reset", m_valid[0] == 1'b0, longint'(m_valid[0]), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
